// File: rtl/commit_rob_if.sv
// Bus bundle for commit_rob: dispatch, per-unit results, register-file commit and PC redirect.
// The slave modport is the reorder buffer; the master modport is the surrounding pipeline.
interface commit_rob_if #(
    parameter int XLEN      = 32,
    parameter int NUM_UNITS = 4,
    parameter int TAG_W     = 4
);
    logic                      disp_tvalid;
    logic                      disp_tready;
    logic [4:0]                disp_rd;
    logic [XLEN-1:0]           disp_pc;
    logic [TAG_W-1:0]          disp_tag;

    logic [NUM_UNITS-1:0]       res_tvalid;
    logic [NUM_UNITS*TAG_W-1:0] res_tag;
    logic [NUM_UNITS*XLEN-1:0]  res_data;
    logic [NUM_UNITS-1:0]       res_redirect;
    logic [NUM_UNITS*XLEN-1:0]  res_new_pc;

    logic                      wbrf_tvalid;
    logic                      wbrf_tready;
    logic [4:0]                wbrf_rd;
    logic [XLEN-1:0]           wbrf_wdata;

    logic                      wbpcg_tvalid;
    logic                      wbpcg_tready;
    logic [XLEN-1:0]           wbpcg_tdata;

    logic                      flush;

    // Handshakes: a transfer happens on a clock edge where tvalid && tready; once raised,
    // tvalid and its payload hold until that edge. Results have no ready and are always taken.
    modport master (
        output disp_tvalid, disp_rd, disp_pc,
        output res_tvalid, res_tag, res_data, res_redirect, res_new_pc,
        output wbrf_tready, wbpcg_tready,
        input  disp_tready, disp_tag,
        input  wbrf_tvalid, wbrf_rd, wbrf_wdata,
        input  wbpcg_tvalid, wbpcg_tdata, flush
    );

    modport slave (
        input  disp_tvalid, disp_rd, disp_pc,
        input  res_tvalid, res_tag, res_data, res_redirect, res_new_pc,
        input  wbrf_tready, wbpcg_tready,
        output disp_tready, disp_tag,
        output wbrf_tvalid, wbrf_rd, wbrf_wdata,
        output wbpcg_tvalid, wbpcg_tdata, flush
    );
endinterface

// File: rtl/commit_rob.sv
// In-order commit reorder buffer: out-of-order result writeback, in-order retire, redirect flush.
// Define COMMIT_ROB_BYPASS_EN to forward a head-matching result straight to the commit port.
module commit_rob #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 8,
    parameter int NUM_UNITS = 4,
    parameter int TAG_W     = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    commit_rob_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    typedef logic [IDX_W:0] ptr_t;

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [DEPTH-1:0] redir_q, redir_d;
    logic [4:0]       rd_q     [DEPTH];
    logic [4:0]       rd_d     [DEPTH];
    logic [XLEN-1:0]  data_q   [DEPTH];
    logic [XLEN-1:0]  data_d   [DEPTH];
    logic [XLEN-1:0]  new_pc_q [DEPTH];
    logic [XLEN-1:0]  new_pc_d [DEPTH];
    ptr_t             head_q, head_d;
    ptr_t             tail_q, tail_d;
    logic             epoch_q, epoch_d;

    logic [IDX_W-1:0] head_idx, tail_idx;
    logic             full, disp_fire, retire;
    logic             head_done, head_redir;
    logic [XLEN-1:0]  head_data, head_new_pc;

    assign head_idx  = head_q[IDX_W-1:0];
    assign tail_idx  = tail_q[IDX_W-1:0];
    assign full      = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign disp_fire = bus.disp_tvalid && !full;

    // disp_tready depends only on registered pointers, never on the commit handshake.
    assign bus.disp_tready = !full;
    assign bus.disp_tag    = {epoch_q, tail_idx};

`ifdef COMMIT_ROB_BYPASS_EN
    always_comb begin
        head_done   = done_q[head_idx];
        head_redir  = redir_q[head_idx];
        head_data   = data_q[head_idx];
        head_new_pc = new_pc_q[head_idx];
        if (vld_q[head_idx] && !done_q[head_idx]) begin
            // Descending scan so the lowest-numbered matching unit is the one forwarded.
            for (int u = NUM_UNITS - 1; u >= 0; u--) begin
                if (bus.res_tvalid[u] && (bus.res_tag[u*TAG_W +: TAG_W] == {epoch_q, head_idx})) begin
                    head_done   = 1'b1;
                    head_redir  = bus.res_redirect[u];
                    head_data   = bus.res_data[u*XLEN +: XLEN];
                    head_new_pc = bus.res_new_pc[u*XLEN +: XLEN];
                end
            end
        end
    end
`else
    assign head_done   = done_q[head_idx];
    assign head_redir  = redir_q[head_idx];
    assign head_data   = data_q[head_idx];
    assign head_new_pc = new_pc_q[head_idx];
`endif

    assign bus.wbrf_tvalid  = vld_q[head_idx] && head_done;
    assign bus.wbrf_rd      = rd_q[head_idx];
    assign bus.wbrf_wdata   = head_data;
    assign bus.wbpcg_tvalid = bus.wbrf_tvalid && head_redir;
    assign bus.wbpcg_tdata  = head_new_pc;

    assign retire    = bus.wbrf_tvalid && bus.wbrf_tready && (!head_redir || bus.wbpcg_tready);
    assign bus.flush = retire && head_redir;

    always_comb begin
        vld_d    = vld_q;
        done_d   = done_q;
        redir_d  = redir_q;
        rd_d     = rd_q;
        data_d   = data_q;
        new_pc_d = new_pc_q;
        head_d   = head_q;
        tail_d   = tail_q;
        epoch_d  = epoch_q;

        // Completed entries are frozen so a held commit payload cannot change underneath.
        for (int u = NUM_UNITS - 1; u >= 0; u--) begin
            if (bus.res_tvalid[u] && (bus.res_tag[u*TAG_W + IDX_W] == epoch_q)
                && vld_q[bus.res_tag[u*TAG_W +: IDX_W]] && !done_q[bus.res_tag[u*TAG_W +: IDX_W]]) begin
                done_d[bus.res_tag[u*TAG_W +: IDX_W]]   = 1'b1;
                redir_d[bus.res_tag[u*TAG_W +: IDX_W]]  = bus.res_redirect[u];
                data_d[bus.res_tag[u*TAG_W +: IDX_W]]   = bus.res_data[u*XLEN +: XLEN];
                new_pc_d[bus.res_tag[u*TAG_W +: IDX_W]] = bus.res_new_pc[u*XLEN +: XLEN];
            end
        end

        if (disp_fire) begin
            vld_d[tail_idx]   = 1'b1;
            done_d[tail_idx]  = 1'b0;
            redir_d[tail_idx] = 1'b0;
            rd_d[tail_idx]    = bus.disp_rd;
            tail_d            = tail_q + ptr_t'(1);
        end

        if (retire) begin
            head_d = head_q + ptr_t'(1);
            if (head_redir) begin
                // Everything younger is dead, including a dispatch accepted this cycle.
                vld_d   = '0;
                done_d  = '0;
                tail_d  = head_q + ptr_t'(1);
                epoch_d = !epoch_q;
            end else begin
                vld_d[head_idx]  = 1'b0;
                done_d[head_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            done_q  <= '0;
            redir_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            epoch_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]     <= '0;
                data_q[i]   <= '0;
                new_pc_q[i] <= '0;
            end
        end else begin
            vld_q    <= vld_d;
            done_q   <= done_d;
            redir_q  <= redir_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            new_pc_q <= new_pc_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            epoch_q  <= epoch_d;
        end
    end
endmodule

// File: tb/tb_commit_rob.sv
// Directed bench for commit_rob: program-order queue model checked every cycle, plus literal
// expectations for fill/empty, out-of-order completion, redirect, stale results, back-pressure, wrap/reset.
module tb_commit_rob;
    localparam int XLEN      = 32;
    localparam int DEPTH     = 8;
    localparam int NUM_UNITS = 4;
    localparam int TAG_W     = 4;
    localparam int IDX_W     = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    commit_rob_if #(.XLEN(XLEN), .NUM_UNITS(NUM_UNITS), .TAG_W(TAG_W)) bus ();

    commit_rob #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_UNITS(NUM_UNITS), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: live instructions in program order; slot positions are plain counters.
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [4:0]       rd;
        bit               done;
        bit               redir;
        logic [XLEN-1:0]  data;
        logic [XLEN-1:0]  npc;
    } ent_t;

    ent_t        rob_q[$];
    int unsigned alloc_n   = 0;
    int unsigned retired_n = 0;
    bit          m_epoch   = 1'b0;

    logic [36:0]     exp_q[$];
    logic [36:0]     got_q[$];
    logic [XLEN-1:0] flush_pc_q[$];

    function automatic logic [TAG_W-1:0] next_tag();
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(alloc_n % DEPTH);
        return {m_epoch, idx};
    endfunction

    function automatic void head_view(output bit ok, output bit redir, output logic [4:0] rd,
                                      output logic [XLEN-1:0] data, output logic [XLEN-1:0] npc);
        ok = 0; redir = 0; rd = '0; data = '0; npc = '0;
        if (rob_q.size() == 0) return;
        ok = rob_q[0].done; redir = rob_q[0].redir; rd = rob_q[0].rd;
        data = rob_q[0].data; npc = rob_q[0].npc;
`ifdef COMMIT_ROB_BYPASS_EN
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (!ok && bus.res_tvalid[u] && bus.res_tag[u*TAG_W +: TAG_W] == rob_q[0].tag) begin
                ok = 1; redir = bus.res_redirect[u];
                data = bus.res_data[u*XLEN +: XLEN]; npc = bus.res_new_pc[u*XLEN +: XLEN];
            end
        end
`endif
    endfunction

    task automatic model_step();
        bit ok, rdr, ret;
        logic [4:0] rd;
        logic [XLEN-1:0] d, np;
        int sz;
        ent_t e;
        head_view(ok, rdr, rd, d, np);
        ret = ok && bus.wbrf_tready && (!rdr || bus.wbpcg_tready);
        sz  = rob_q.size();
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (bus.res_tvalid[u]) begin
                foreach (rob_q[k]) begin
                    if (rob_q[k].tag == bus.res_tag[u*TAG_W +: TAG_W] && !rob_q[k].done) begin
                        rob_q[k].done  = 1;
                        rob_q[k].redir = bus.res_redirect[u];
                        rob_q[k].data  = bus.res_data[u*XLEN +: XLEN];
                        rob_q[k].npc   = bus.res_new_pc[u*XLEN +: XLEN];
                    end
                end
            end
        end
        if (bus.disp_tvalid && sz < DEPTH) begin
            e.tag = next_tag(); e.rd = bus.disp_rd; e.done = 0; e.redir = 0; e.data = '0; e.npc = '0;
            rob_q.push_back(e);
            alloc_n++;
        end
        if (ret) begin
            retired_n++;
            if (rdr) begin
                rob_q.delete();
                alloc_n = retired_n;
                m_epoch = !m_epoch;
            end else begin
                rob_q.delete(0);
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rob_q.delete();
            alloc_n = 0; retired_n = 0; m_epoch = 0;
        end else begin
            model_step();
        end
    end

    // Compare process: outputs checked mid-low-phase every cycle, after inputs have settled.
    always @(negedge clk) begin : cmp
        bit ok, rdr;
        logic [4:0] rd;
        logic [XLEN-1:0] d, np;
        #2;
        head_view(ok, rdr, rd, d, np);
        check("disp_tready", bus.disp_tready, rob_q.size() < DEPTH);
        check("disp_tag", bus.disp_tag, next_tag());
        check("wbrf_tvalid", bus.wbrf_tvalid, ok);
        if (ok) begin
            check("wbrf_rd", bus.wbrf_rd, rd);
            check("wbrf_wdata", bus.wbrf_wdata, d);
            check("wbpcg_tvalid", bus.wbpcg_tvalid, rdr);
            if (rdr) check("wbpcg_tdata", bus.wbpcg_tdata, np);
        end else begin
            check("wbpcg_tvalid", bus.wbpcg_tvalid, 1'b0);
        end
        check("flush", bus.flush, ok && rdr && bus.wbrf_tready && bus.wbpcg_tready);
        if (!rst && bus.wbrf_tvalid && bus.wbrf_tready && (!bus.wbpcg_tvalid || bus.wbpcg_tready))
            got_q.push_back({bus.wbrf_rd, bus.wbrf_wdata});
        if (!rst && bus.flush) flush_pc_q.push_back(bus.wbpcg_tdata);
    end

    task automatic step();
        @(negedge clk);
        bus.disp_tvalid  = 1'b0;
        bus.res_tvalid   = '0;
        bus.res_redirect = '0;
    endtask

    task automatic set_disp(input logic [4:0] rd);
        bus.disp_tvalid = 1'b1;
        bus.disp_rd     = rd;
        bus.disp_pc     = 32'h1000 + 32'(rd) * 4;
    endtask

    task automatic disp_chk(input logic [4:0] rd, input logic [TAG_W-1:0] exp_tag);
        step();
        #1;
        check("disp_tag_lit", bus.disp_tag, exp_tag);
        set_disp(rd);
    endtask

    task automatic set_res(input int u, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] d,
                           input bit r, input logic [XLEN-1:0] npc);
        bus.res_tvalid[u]                = 1'b1;
        bus.res_tag[u*TAG_W +: TAG_W]    = tag;
        bus.res_data[u*XLEN +: XLEN]     = d;
        bus.res_redirect[u]              = r;
        bus.res_new_pc[u*XLEN +: XLEN]   = npc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.disp_tvalid = 1'b0; bus.res_tvalid = '0; bus.res_redirect = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got_q.delete(); exp_q.delete(); flush_pc_q.delete();
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (rob_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_in_budget", rob_q.size() == 0, 1'b1);
        step();
    endtask

    task automatic drain_check(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) check(name, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        bus.disp_tvalid = 0; bus.disp_rd = '0; bus.disp_pc = '0;
        bus.res_tvalid = '0; bus.res_tag = '0; bus.res_data = '0;
        bus.res_redirect = '0; bus.res_new_pc = '0;
        bus.wbrf_tready = 1'b1; bus.wbpcg_tready = 1'b1;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        step(); #1;
        check("rst_disp_tready", bus.disp_tready, 1'b1);
        check("rst_disp_tag", bus.disp_tag, 4'h0);
        check("rst_wbrf_tvalid", bus.wbrf_tvalid, 1'b0);
        check("rst_wbpcg_tvalid", bus.wbpcg_tvalid, 1'b0);
        check("rst_flush", bus.flush, 1'b0);

        // Fill / empty
        for (int i = 0; i < 8; i++) disp_chk(5'(i + 1), 4'(i));
        step(); #1;
        check("full_tready", bus.disp_tready, 1'b0);
        for (int u = 0; u < 4; u++) set_res(u, 4'(u), 32'((u + 1) * 16), 1'b0, '0);
        step();
        for (int u = 0; u < 4; u++) set_res(u, 4'(u + 4), 32'((u + 5) * 16), 1'b0, '0);
        for (int i = 0; i < 8; i++) exp_q.push_back({5'(i + 1), 32'((i + 1) * 16)});
        wait_empty(40);
        drain_check("fill_commit");

        // Out-of-order completion: tags 0,1,2 again after the wrap
        disp_chk(5'd1, 4'd0);
        disp_chk(5'd2, 4'd1);
        disp_chk(5'd3, 4'd2);
        step();
        set_res(3, 4'd2, 32'h222, 1'b0, '0);
        step(); #1;
        check("ooo_wait", bus.wbrf_tvalid, 1'b0);
        set_res(1, 4'd0, 32'h200, 1'b0, '0);
        step(); #1;
`ifndef COMMIT_ROB_BYPASS_EN
        check("ooo_lat1_valid", bus.wbrf_tvalid, 1'b1);
        check("ooo_lat1_data", bus.wbrf_wdata, 32'h200);
`endif
        set_res(0, 4'd1, 32'h201, 1'b0, '0);
        exp_q.push_back({5'd1, 32'h200});
        exp_q.push_back({5'd2, 32'h201});
        exp_q.push_back({5'd3, 32'h222});
        wait_empty(20);
        drain_check("ooo_commit");

        // Redirect flush from a clean start
        do_reset();
        disp_chk(5'd10, 4'd0);
        disp_chk(5'd11, 4'd1);
        disp_chk(5'd12, 4'd2);
        disp_chk(5'd13, 4'd3);
        step();
        set_res(0, 4'd2, 32'hC2, 1'b0, '0);
        set_res(1, 4'd3, 32'hC3, 1'b0, '0);
        step();
        set_res(2, 4'd1, 32'hA1, 1'b1, 32'h100);
        step();
        set_res(0, 4'd0, 32'hA0, 1'b0, '0);
        exp_q.push_back({5'd10, 32'hA0});
        exp_q.push_back({5'd11, 32'hA1});
        wait_empty(20);
        drain_check("redir_commit");
        check("redir_flush_count", flush_pc_q.size(), 1);
        if (flush_pc_q.size() > 0) check("redir_new_pc", flush_pc_q.pop_front(), 32'h100);
        disp_chk(5'd20, 4'hA);

        // Stale old-epoch result for index 2 is dropped
        step();
        set_res(1, 4'h2, 32'hDEAD, 1'b0, '0);
        step();
        step(); #1;
        check("stale_drop", bus.wbrf_tvalid, 1'b0);
        set_res(0, 4'hA, 32'h55, 1'b0, '0);
        exp_q.push_back({5'd20, 32'h55});
        wait_empty(10);
        drain_check("stale_commit");

        // Back-pressure on the PC generator
        disp_chk(5'd21, 4'hB);
        bus.wbpcg_tready = 1'b0;
        step();
        set_res(0, 4'hB, 32'h77, 1'b1, 32'h200);
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            check("bp_wbrf_tvalid", bus.wbrf_tvalid, 1'b1);
            check("bp_wbpcg_tvalid", bus.wbpcg_tvalid, 1'b1);
            check("bp_wbpcg_tdata", bus.wbpcg_tdata, 32'h200);
            check("bp_wbrf_wdata", bus.wbrf_wdata, 32'h77);
            check("bp_no_flush", bus.flush, 1'b0);
        end
        step();
        bus.wbpcg_tready = 1'b1;
        #1;
        check("bp_flush", bus.flush, 1'b1);
        exp_q.push_back({5'd21, 32'h77});
        step(); #1;
        check("bp_after_valid", bus.wbrf_tvalid, 1'b0);
        check("bp_after_tag", bus.disp_tag, 4'h4);
        drain_check("bp_commit");
        check("bp_new_pc", flush_pc_q.size() > 0 ? flush_pc_q.pop_front() : 32'h0, 32'h200);

        // Wrap and reset
        do_reset();
        for (int i = 0; i < 20; i++) begin
            disp_chk(5'(i % 31 + 1), {1'b0, 3'(i % 8)});
            step();
            set_res(0, {1'b0, 3'(i % 8)}, 32'(i + 32'h300), 1'b0, '0);
            exp_q.push_back({5'(i % 31 + 1), 32'(i + 32'h300)});
        end
        wait_empty(20);
        drain_check("wrap_commit");
        disp_chk(5'd1, 4'd4);
        disp_chk(5'd2, 4'd5);
        disp_chk(5'd3, 4'd6);
        step();
        rst = 1'b1;
        #1;
        check("midrst_disp_tready", bus.disp_tready, 1'b1);
        check("midrst_disp_tag", bus.disp_tag, 4'h0);
        check("midrst_wbrf_tvalid", bus.wbrf_tvalid, 1'b0);
        check("midrst_wbpcg_tvalid", bus.wbpcg_tvalid, 1'b0);
        check("midrst_flush", bus.flush, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        disp_chk(5'd7, 4'd0);
        step();
        set_res(0, 4'd0, 32'h99, 1'b0, '0);
        exp_q.push_back({5'd7, 32'h99});
        wait_empty(10);
        drain_check("post_rst_commit");

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
